// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C bus condition tracker.
package i2c_pkg;

    localparam int unsigned I2C_BITS_PER_BYTE = 8;
    localparam int unsigned I2C_BIT_CNT_W     = 4;

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StAck
    } i2c_state_e;

endpackage

// File: rtl/i2c_scl_timeout_counter.sv
// Counts consecutive cycles with SCL held low while the bus is busy; flags expiry
// on the TIMEOUT_CYCLES-th counted cycle.
module i2c_scl_timeout_counter #(
    parameter int unsigned TIMEOUT_CYCLES = 1000
) (
    input  logic clk,
    input  logic resetn,
    input  logic run,
    output logic expired
);

    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);
    localparam logic [CntW-1:0] CntOne  = CntW'(1);

    logic [CntW-1:0] count_q;

    assign expired = run && (count_q == CntLast);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            count_q <= '0;
        end else if (!run || expired) begin
            count_q <= '0;
        end else begin
            count_q <= count_q + CntOne;
        end
    end

endmodule

// File: rtl/i2c_bus_condition_tracker.sv
// I2C START/STOP/data/ACK tracker fed by SCL/SDA edge pulses.
// Optional SCL-low timeout enabled by defining I2C_BUS_TRACKER_TIMEOUT_EN.
module i2c_bus_condition_tracker
    import i2c_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1000
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       tracker_en,
    input  logic       scl_in,
    input  logic       sda_in,
    input  logic       scl_rise_edge,
    input  logic       scl_fall_edge,
    input  logic       sda_rise_edge,
    input  logic       sda_fall_edge,
    output logic       start_det,
    output logic       rstart_det,
    output logic       stop_det,
    output logic       bus_busy,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       ack_valid,
    output logic       ack_nack,
    output logic [3:0] bit_cnt,
    output logic       bus_error,
    output logic       bus_timeout
);

    localparam logic [I2C_BIT_CNT_W-1:0] CntOne  = I2C_BIT_CNT_W'(1);
    localparam logic [I2C_BIT_CNT_W-1:0] CntLast = I2C_BIT_CNT_W'(I2C_BITS_PER_BYTE - 1);

    i2c_state_e state_q, state_d;
    logic       pending_q, pending_d;
    logic       sample_q, sample_d;
    logic [6:0] shreg_q, shreg_d;
    logic [7:0] byte_data_d;
    logic [3:0] bit_cnt_d;
    logic       ack_nack_d, bus_busy_d;
    logic       start_det_d, rstart_det_d, stop_det_d, byte_valid_d, ack_valid_d;
    logic       bus_error_d, bus_timeout_d;

    logic start_cond, stop_cond, commit, in_xfer, framing_err, timeout_hit;

    // A condition needs SDA to move while SCL is stable high.
    assign start_cond = sda_fall_edge && scl_in && !scl_fall_edge && !scl_rise_edge;
    assign stop_cond  = sda_rise_edge && scl_in && !scl_fall_edge && !scl_rise_edge;
    assign in_xfer    = (state_q != StIdle);
    assign commit     = scl_fall_edge && pending_q && in_xfer;
    assign framing_err = (state_q == StAck) || ((state_q == StShift) && (bit_cnt != '0));

`ifdef I2C_BUS_TRACKER_TIMEOUT_EN
    i2c_scl_timeout_counter #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_scl_timeout (
        .clk    (clk),
        .resetn (resetn),
        .run    (tracker_en && bus_busy && !scl_in && in_xfer),
        .expired(timeout_hit)
    );
`else
    logic [31:0] unused_timeout_cycles;
    assign unused_timeout_cycles = TIMEOUT_CYCLES;
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (!tracker_en || timeout_hit) begin
            state_d = StIdle;
        end else if (start_cond) begin
            state_d = StShift;
        end else if (stop_cond) begin
            state_d = StIdle;
        end else if (commit) begin
            if (state_q == StShift && bit_cnt == CntLast) begin
                state_d = StAck;
            end else if (state_q == StAck) begin
                state_d = StShift;
            end
        end
    end

    always_comb begin
        pending_d     = pending_q;
        sample_d      = sample_q;
        shreg_d       = shreg_q;
        byte_data_d   = byte_data;
        bit_cnt_d     = bit_cnt;
        ack_nack_d    = ack_nack;
        bus_busy_d    = bus_busy;
        start_det_d   = 1'b0;
        rstart_det_d  = 1'b0;
        stop_det_d    = 1'b0;
        byte_valid_d  = 1'b0;
        ack_valid_d   = 1'b0;
        bus_error_d   = 1'b0;
        bus_timeout_d = 1'b0;
        if (!tracker_en || timeout_hit) begin
            bus_timeout_d = tracker_en;
            bus_busy_d    = 1'b0;
            pending_d     = 1'b0;
            bit_cnt_d     = '0;
            shreg_d       = '0;
        end else if (start_cond) begin
            start_det_d  = !in_xfer;
            rstart_det_d = in_xfer;
            bus_error_d  = in_xfer && framing_err;
            bus_busy_d   = 1'b1;
            pending_d    = 1'b0;
            bit_cnt_d    = '0;
            shreg_d      = '0;
        end else if (stop_cond) begin
            stop_det_d  = 1'b1;
            bus_error_d = in_xfer && framing_err;
            bus_busy_d  = 1'b0;
            pending_d   = 1'b0;
            bit_cnt_d   = '0;
            shreg_d     = '0;
        end else if (in_xfer && scl_rise_edge) begin
            sample_d  = sda_in;
            pending_d = 1'b1;
        end else if (commit) begin
            pending_d = 1'b0;
            if (state_q == StShift) begin
                shreg_d   = {shreg_q[5:0], sample_q};
                bit_cnt_d = bit_cnt + CntOne;
                if (bit_cnt == CntLast) begin
                    byte_data_d  = {shreg_q, sample_q};
                    byte_valid_d = 1'b1;
                end
            end else begin
                ack_valid_d = 1'b1;
                ack_nack_d  = sample_q;
                bit_cnt_d   = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            pending_q   <= 1'b0;
            sample_q    <= 1'b0;
            shreg_q     <= '0;
            byte_data   <= '0;
            bit_cnt     <= '0;
            ack_nack    <= 1'b0;
            bus_busy    <= 1'b0;
            start_det   <= 1'b0;
            rstart_det  <= 1'b0;
            stop_det    <= 1'b0;
            byte_valid  <= 1'b0;
            ack_valid   <= 1'b0;
            bus_error   <= 1'b0;
            bus_timeout <= 1'b0;
        end else begin
            pending_q   <= pending_d;
            sample_q    <= sample_d;
            shreg_q     <= shreg_d;
            byte_data   <= byte_data_d;
            bit_cnt     <= bit_cnt_d;
            ack_nack    <= ack_nack_d;
            bus_busy    <= bus_busy_d;
            start_det   <= start_det_d;
            rstart_det  <= rstart_det_d;
            stop_det    <= stop_det_d;
            byte_valid  <= byte_valid_d;
            ack_valid   <= ack_valid_d;
            bus_error   <= bus_error_d;
            bus_timeout <= bus_timeout_d;
        end
    end

endmodule
